// File: rtl/counter_4.sv
// counter_4 -- free-running modulo-(MAX_VALUE+1) up-counter.
//
// The count advances by STEP on every rising edge of clk. When the sum
// would pass MAX_VALUE, it wraps to (y + STEP) - (MAX_VALUE + 1).
// A synchronous, active-high rst loads RESET_VALUE and has priority.
// y comes straight from a register, so no input reaches it combinationally.
//
// Optional feature: define COUNTER_4_TC_EN to add the registered
// terminal-count output tc. tc is high while y == MAX_VALUE, but only
// when that value was loaded by counting rather than by reset.
//
// Legal configuration: WIDTH 2..16, RESET_VALUE <= MAX_VALUE,
// MAX_VALUE <= 2^WIDTH-1, STEP 1..MAX_VALUE.

module counter_4 #(
  parameter int WIDTH       = 4,
  parameter int RESET_VALUE = 0,
  parameter int MAX_VALUE   = (1 << WIDTH) - 1,
  parameter int STEP        = 1
) (
  input  logic             clk,
  input  logic             rst,
`ifdef COUNTER_4_TC_EN
  output logic             tc,
`endif
  output logic [WIDTH-1:0] y
);

  // Constants widened to WIDTH+1 bits so the overflow compare is exact.
  // MAX_VALUE+1 can equal 2^WIDTH, which needs the extra bit.
  localparam logic [WIDTH:0]   MAX_EXT   = (WIDTH+1)'(MAX_VALUE);
  localparam logic [WIDTH:0]   WRAP_EXT  = (WIDTH+1)'(MAX_VALUE + 1);
  localparam logic [WIDTH:0]   STEP_EXT  = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MAX_VALUE);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   wrapped;

  // Next count: add STEP, then fold back into 0..MAX_VALUE on overflow.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    count_d = count_q;
    sum     = {1'b0, count_q} + STEP_EXT;
    wrapped = sum - WRAP_EXT;
    if (sum > MAX_EXT) begin
      count_d = wrapped[WIDTH-1:0];
    end else begin
      count_d = sum[WIDTH-1:0];
    end
  end

  // Count register; the synchronous reset overrides counting.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every
    // register samples its pre-edge inputs.
    if (rst) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign y = count_q;

`ifdef COUNTER_4_TC_EN
  logic tc_q;

  // Terminal count goes high on the same edge that loads MAX_VALUE by counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      tc_q <= 1'b0;
    end else begin
      tc_q <= (count_d == MAX_VAL);
    end
  end

  assign tc = tc_q;
`endif

endmodule

// File: tb/tb_counter_4.sv
// tb_counter_4 -- self-checking bench for counter_4.
// It runs a default instance and a swept instance (MAX_VALUE=9, STEP=3,
// RESET_VALUE=2) side by side. Both are compared against a modular-arithmetic
// reference model. rst is driven and outputs are sampled on the falling edge.
// It also covers COUNTER_4_TC_EN when that macro is defined.

module tb_counter_4;

  localparam int W      = 4;
  localparam int MAX_A  = 15;
  localparam int RV_A   = 0;
  localparam int STEP_A = 1;
  localparam int MAX_B  = 9;
  localparam int RV_B   = 2;
  localparam int STEP_B = 3;

  logic         clk;
  logic         rst;
  logic [W-1:0] y_a;
  logic [W-1:0] y_b;
`ifdef COUNTER_4_TC_EN
  logic         tc_a;
  logic         tc_b;
`endif

  int n_checks;
  int n_fail;
  int model_a;
  int model_b;
  int sweep_tab[11];

  counter_4 #(.WIDTH(W)) u_dut_a (
    .clk (clk),
    .rst (rst),
`ifdef COUNTER_4_TC_EN
    .tc  (tc_a),
`endif
    .y   (y_a)
  );

  counter_4 #(
    .WIDTH(W), .RESET_VALUE(RV_B), .MAX_VALUE(MAX_B), .STEP(STEP_B)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
`ifdef COUNTER_4_TC_EN
    .tc  (tc_b),
`endif
    .y   (y_b)
  );

  // 200 ns clock period.
  initial clk = 1'b0;
  always #100 clk = ~clk;

  // Watchdog so the bench always terminates on its own.
  initial begin
    #(200 * 5000);
    $display("FAIL watchdog: time limit reached, got no end of test, required end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Call this at a falling edge. It drives rst, lets one rising edge pass,
  // advances the reference model, and compares at the next falling edge.
  task automatic step(input logic r);
    rst = r;
    @(posedge clk);
    if (r) begin
      model_a = RV_A;
      model_b = RV_B;
    end else begin
      model_a = (model_a + STEP_A) % (MAX_A + 1);
      model_b = (model_b + STEP_B) % (MAX_B + 1);
    end
    @(negedge clk);
    check("y", int'(y_a), model_a);
    check("y_sweep", int'(y_b), model_b);
`ifdef COUNTER_4_TC_EN
    check("tc", int'(tc_a), int'(!r && model_a == MAX_A));
    check("tc_sweep", int'(tc_b), int'(!r && model_b == MAX_B));
`endif
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    model_a   = 0;
    model_b   = 0;
    sweep_tab = '{2, 5, 8, 1, 4, 7, 0, 3, 6, 9, 2};
    rst       = 1'b0;
    @(negedge clk);

    // Reset hold: two sampled edges with rst high.
    step(1'b1);
    check("reset_hold_1", int'(y_a), 0);
    check("sweep_seq_0", int'(y_b), sweep_tab[0]);
    step(1'b1);
    check("reset_hold_2", int'(y_a), 0);

    // Free run for 20 edges: 1..15, 0..4. The swept instance follows its table.
    for (int i = 0; i < 20; i++) begin
      step(1'b0);
      check("free_run", int'(y_a), (i < 15) ? i + 1 : i - 15);
      if (i < 10) check("sweep_seq", int'(y_b), sweep_tab[i + 1]);
    end

    // A short rst pulse between rising edges must have no effect.
    #20 rst = 1'b1;
    #20 rst = 1'b0;
    @(negedge clk);
    model_a = (model_a + STEP_A) % (MAX_A + 1);
    model_b = (model_b + STEP_B) % (MAX_B + 1);
    check("glitch_ignored", int'(y_a), model_a);
    check("glitch_ignored_sweep", int'(y_b), model_b);

    // Reset mid-count, applied while y == 9.
    for (int k = 0; k < 32 && model_a != 9; k++) step(1'b0);
    check("reach_9", int'(y_a), 9);
    step(1'b1);
    check("mid_reset", int'(y_a), 0);
    step(1'b0);
    check("after_mid_reset", int'(y_a), 1);

    // Reset at the terminal value, applied while y == 15.
    for (int k = 0; k < 32 && model_a != MAX_A; k++) step(1'b0);
    check("reach_max", int'(y_a), MAX_A);
`ifdef COUNTER_4_TC_EN
    check("tc_at_max", int'(tc_a), 1);
`endif
    step(1'b1);
    check("terminal_reset", int'(y_a), 0);
`ifdef COUNTER_4_TC_EN
    check("tc_cleared", int'(tc_a), 0);
`endif

    // Randomized run: rst is asserted on about 1 in 12 edges.
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
